logic_unit_arbiter: RTL and testbench
=====================================

// Module: logic_unit_arbiter
// PURPOSE
//  Shares one combinational 19-bit logic unit (AND/OR/XOR/NOT-A/NOT-B, flags eq/gt/lt/za/zb) between two requesters.
//  Arbitrates, registers operands onto the unit's inputs, captures the result and flags, and returns them to the winner.
//  Sits between the CPU's decode/execute stage (req0) and a secondary client such as a DMA/compare engine (req1).
// PARAMETERS
//  WIDTH   19  data width of operands, result, and logic-unit ports
//  OPW     5   opcode width
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  reqN_valid   in   1      N=0,1: request present
//  reqN_ready   out  1      N=0,1: arbiter accepts request this cycle
//  reqN_a       in   WIDTH  operand A
//  reqN_b       in   WIDTH  operand B
//  reqN_op      in   OPW    opcode
//  rspN_valid   out  1      N=0,1: response held for requester N
//  rspN_ready   in   1      requester N consumes response
//  rspN_data    out  WIDTH  captured result
//  rspN_flags   out  5      {eq,gt,lt,za,zb} captured from unit
//  rspN_err     out  1      opcode was not one of 01000..01100
//  lu_a, lu_b   out  WIDTH  registered operands to logic unit
//  lu_opcode    out  OPW    registered opcode to logic unit
//  lu_out       in   WIDTH  logic unit result
//  lu_eq, lu_gt, lu_lt, lu_za, lu_zb  in  1  logic unit flags
//  busy         out  1      high whenever state != IDLE
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state=IDLE; rr pointer favours req0; all outputs 0; lu_a/lu_b/lu_opcode=0. Transaction in flight is dropped; no response is issued.
//  - FSM: IDLE -> EXEC -> RESP -> IDLE.
//    - IDLE: grant computed combinationally from reqN_valid and the priority scheme. reqN_ready=1 only for the granted N, and only in IDLE.
//      On handshake at edge E: latch a/b/op into lu_*, record owner, -> EXEC.
//    - EXEC (one cycle, E+1): lu_* stable. At end of cycle, capture lu_out and flags into the owner's rsp regs, -> RESP.
//    - RESP: rspN_valid=1 for owner only from cycle E+2. Data/flags/err stable until rspN_ready=1, then -> IDLE.
//  - Latency accept->rsp_valid = 2 cycles. Minimum issue interval is 3 cycles (rsp consumed in the first RESP cycle).
//  - Requests arriving outside IDLE are not accepted (ready=0). Requesters must hold valid and payload stable until ready.
//  - Invalid opcode (not 01000..01100): forwarded to lu_opcode unchanged, but rsp_data forced to 0 and rsp_err=1. Flags are still captured.
//  - Round-robin: with both valid in IDLE, grant goes to the requester not granted last. The pointer updates only on handshake. A single valid requester always wins.
//  - Widths: no arithmetic; data is passed through bit-exact at WIDTH.
//  - lu_* hold their last value outside EXEC (change only on accept).
//  - rsp regs of the non-owner keep valid=0. Data/flags of a consumed response hold their last value.
// CONFIGURATION
//  - LUARB_FIXED_PRIO_EN defined: req0 always wins when both are valid; rr pointer removed.
//  - Undefined (default): round-robin as above.
// TESTING
//  1. rst=1 for 2 cycles with both reqs valid -> all ready/rsp_valid=0, lu_*=0, busy=0.
//  2. req0 a=0x7FFFF b=0x00F0F op=01000, rsp0_ready=1 -> ready0 at E; rsp0_valid at E+2; data=0x00F0F, flags{eq,gt,lt,za,zb}=01000.
//  3. Both valid continuously, rsp ready=1 (default build) -> grants alternate 0,1,0,1 at 3-cycle spacing.
//     With LUARB_FIXED_PRIO_EN: req1 never granted.
//  4. req1 op=11111 a=b=0 -> rsp1_err=1, data=0, flags=10011.
//  5. rsp0_ready held 0 for 5 cycles -> rsp0 stable, ready0/ready1 stay 0, busy=1; release -> IDLE next cycle.
//  6. rst asserted during EXEC -> no rsp_valid afterwards; next request is serviced normally starting from req0 priority.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
//
// Shares one combinational logic unit (AND/OR/XOR/NOT-A/NOT-B with
// eq/gt/lt/za/zb flags) between two requesters. A request is accepted in
// IDLE, its operands are registered onto the unit inputs for one EXEC cycle,
// and the unit result and flags are captured into the winner's response
// registers. The response is held in RESP until the winner consumes it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         request handshake (N = 0 CPU, 1 secondary)
//   reqN_a, reqN_b, reqN_op  request payload
//   rspN_valid/ready         response handshake
//   rspN_data/flags/err      captured result, {eq,gt,lt,za,zb}, bad-opcode
//   lu_a, lu_b, lu_opcode    registered operands to the logic unit
//   lu_out, lu_eq..lu_zb     logic unit result and flags
//   busy                     high whenever the FSM is not IDLE
//
// Configuration
//   LUARB_FIXED_PRIO_EN      when defined, req0 always wins a tie and the
//                            round-robin pointer is removed; otherwise a tie
//                            goes to the requester not granted last.
// ---------------------------------------------------------------------------
module logic_unit_arbiter #(
  parameter int WIDTH = 19,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic [4:0]       rsp0_flags,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [4:0]       rsp1_flags,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [OPW-1:0]   lu_opcode,
  input  logic [WIDTH-1:0] lu_out,
  input  logic             lu_eq,
  input  logic             lu_gt,
  input  logic             lu_lt,
  input  logic             lu_za,
  input  logic             lu_zb,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   gnt_vld;
  logic   gnt_id;
  logic   accept;
  logic   consume;
`ifndef LUARB_FIXED_PRIO_EN
  logic   rr_last;  // requester granted most recently
`endif

  // Legal opcodes are 01000..01100; anything else is flagged as an error.
  function automatic logic op_bad(input logic [OPW-1:0] op);
    return (op < OPW'(8)) || (op > OPW'(12));
  endfunction

  // Result presented to the requester: bad opcodes never leak unit output.
  function automatic logic [WIDTH-1:0] sel_data(input logic [OPW-1:0] op,
                                                input logic [WIDTH-1:0] res);
    return op_bad(op) ? '0 : res;
  endfunction

  // Grant selection from the current request set
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef LUARB_FIXED_PRIO_EN
      gnt_id = 1'b0;
`else
      gnt_id = ~rr_last;
`endif
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  // Ready is suppressed while rst is high so nothing looks accepted during reset.
  assign accept     = (state == IDLE) && gnt_vld && !rst;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept &&  gnt_id;
  assign consume    = owner ? rsp1_ready : rsp0_ready;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = EXEC;
      EXEC:                 state_nxt = RESP;
      RESP:    if (consume) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
`ifndef LUARB_FIXED_PRIO_EN
      rr_last    <= 1'b1;
`endif
      lu_a       <= '0;
      lu_b       <= '0;
      lu_opcode  <= '0;
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_flags <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_flags <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      state <= state_nxt;

      // Accept stage: operands onto the logic unit, owner recorded
      if (accept) begin
        lu_a      <= gnt_id ? req1_a  : req0_a;
        lu_b      <= gnt_id ? req1_b  : req0_b;
        lu_opcode <= gnt_id ? req1_op : req0_op;
        owner     <= gnt_id;
`ifndef LUARB_FIXED_PRIO_EN
        rr_last   <= gnt_id;
`endif
      end

      // Capture stage: unit result lands in the owner's response registers
      if (state == EXEC) begin
        if (!owner) begin
          rsp0_valid <= 1'b1;
          rsp0_data  <= sel_data(lu_opcode, lu_out);
          rsp0_flags <= {lu_eq, lu_gt, lu_lt, lu_za, lu_zb};
          rsp0_err   <= op_bad(lu_opcode);
        end else begin
          rsp1_valid <= 1'b1;
          rsp1_data  <= sel_data(lu_opcode, lu_out);
          rsp1_flags <= {lu_eq, lu_gt, lu_lt, lu_za, lu_zb};
          rsp1_err   <= op_bad(lu_opcode);
        end
      end

      // Response stage: valid drops on consume, payload holds its last value
      if (state == RESP && consume) begin
        if (!owner) rsp0_valid <= 1'b0;
        else        rsp1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;
  localparam int W  = 19;
  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [OW-1:0] req0_op, req1_op;
  logic          rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [W-1:0]  rsp0_data, rsp1_data;
  logic [4:0]    rsp0_flags, rsp1_flags;
  logic [W-1:0]  lu_a, lu_b, lu_out;
  logic [OW-1:0] lu_opcode;
  logic          lu_eq, lu_gt, lu_lt, lu_za, lu_zb;
  logic          busy;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(W), .OPW(OW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
    .lu_a(lu_a), .lu_b(lu_b), .lu_opcode(lu_opcode), .lu_out(lu_out),
    .lu_eq(lu_eq), .lu_gt(lu_gt), .lu_lt(lu_lt), .lu_za(lu_za), .lu_zb(lu_zb),
    .busy(busy)
  );

  // Combinational logic unit; unknown opcodes give a nonzero pattern
  always_comb begin
    case (lu_opcode)
      5'b01000: lu_out = lu_a & lu_b;
      5'b01001: lu_out = lu_a | lu_b;
      5'b01010: lu_out = lu_a ^ lu_b;
      5'b01011: lu_out = ~lu_a;
      5'b01100: lu_out = ~lu_b;
      default:  lu_out = ~(lu_a ^ lu_b);
    endcase
    lu_eq = (lu_a == lu_b);
    lu_gt = (lu_a > lu_b);
    lu_lt = (lu_a < lu_b);
    lu_za = (lu_a == '0);
    lu_zb = (lu_b == '0);
  end

  typedef struct packed {
    logic [W-1:0] data;
    logic [4:0]   flags;
    logic         err;
  } rsp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  rsp_t q0[$];
  rsp_t q1[$];

  // Reference model state (value describes the upcoming cycle)
  bit           m_busy  = 1'b0;
  bit           m_owner = 1'b0;
  bit           m_last  = 1'b1;
  int           m_due   = 0;
  logic [W-1:0] m_a, m_b;
  logic [OW-1:0] m_op;
  bit           hs0 = 1'b0, hs1 = 1'b0;

  function automatic rsp_t ref_rsp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op);
    rsp_t r;
    int   o;
    o       = int'(op);
    r.flags = {a == b, a > b, a < b, a == 0, b == 0};
    r.err   = (o < 8) || (o > 12);
    case (o)
      8:       r.data = a & b;
      9:       r.data = a | b;
      10:      r.data = a ^ b;
      11:      r.data = ~a;
      12:      r.data = ~b;
      default: r.data = '0;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge
  logic eg_v, eg_id, e_r0, e_r1, ev0, ev1;
  always @(negedge clk) begin
    cyc++;
    eg_v = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef LUARB_FIXED_PRIO_EN
      eg_id = 1'b0;
`else
      eg_id = ~m_last;
`endif
    end else begin
      eg_id = req1_valid;
    end
    e_r0 = !rst && !m_busy && eg_v && !eg_id;
    e_r1 = !rst && !m_busy && eg_v &&  eg_id;
    ev0  = m_busy && !m_owner && (cyc >= m_due);
    ev1  = m_busy &&  m_owner && (cyc >= m_due);

    check("req0_ready", 32'(req0_ready), 32'(e_r0));
    check("req1_ready", 32'(req1_ready), 32'(e_r1));
    check("busy",       32'(busy),       32'(m_busy));
    check("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
    check("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
    if (ev0 && q0.size() > 0) begin
      check("rsp0_data",  32'(rsp0_data),  32'(q0[0].data));
      check("rsp0_flags", 32'(rsp0_flags), 32'(q0[0].flags));
      check("rsp0_err",   32'(rsp0_err),   32'(q0[0].err));
    end
    if (ev1 && q1.size() > 0) begin
      check("rsp1_data",  32'(rsp1_data),  32'(q1[0].data));
      check("rsp1_flags", 32'(rsp1_flags), 32'(q1[0].flags));
      check("rsp1_err",   32'(rsp1_err),   32'(q1[0].err));
    end
    if (m_busy && cyc == m_due - 1) begin
      check("lu_a",      32'(lu_a),      32'(m_a));
      check("lu_b",      32'(lu_b),      32'(m_b));
      check("lu_opcode", 32'(lu_opcode), 32'(m_op));
    end

    if (rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      q0.delete();
      q1.delete();
    end else if (e_r0 || e_r1) begin
      m_busy  = 1'b1;
      m_owner = eg_id;
      m_last  = eg_id;
      m_due   = cyc + 2;
      m_a     = eg_id ? req1_a  : req0_a;
      m_b     = eg_id ? req1_b  : req0_b;
      m_op    = eg_id ? req1_op : req0_op;
      if (eg_id) begin q1.push_back(ref_rsp(m_a, m_b, m_op)); hs1 = 1'b1; end
      else       begin q0.push_back(ref_rsp(m_a, m_b, m_op)); hs0 = 1'b1; end
    end else if (ev0 && rsp0_ready) begin
      void'(q0.pop_front());
      m_busy = 1'b0;
    end else if (ev1 && rsp1_ready) begin
      void'(q1.pop_front());
      m_busy = 1'b0;
    end
  end

  // Waits (bounded) for the monitor to see requester n handshake, then drops valid
  task automatic wait_hs(input int n);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (n == 0 && hs0) begin hs0 = 1'b0; req0_valid = 1'b0; return; end
      if (n == 1 && hs1) begin hs1 = 1'b0; req1_valid = 1'b0; return; end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout req%0d: actual=no handshake expected=handshake within 20 cycles", n);
  endtask

  task automatic issue(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op);
    if (n == 0) begin hs0 = 1'b0; req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    else        begin hs1 = 1'b0; req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    wait_hs(n);
  endtask

  task automatic rand_payload(output logic [W-1:0] a, output logic [W-1:0] b, output logic [OW-1:0] op);
    a  = W'($urandom);
    b  = ($urandom_range(0, 5) == 0) ? a : W'($urandom);
    if ($urandom_range(0, 7) == 0) a = '0;
    if ($urandom_range(0, 7) == 0) b = '0;
    op = ($urandom_range(0, 5) == 0) ? OW'($urandom) : OW'(8 + $urandom_range(0, 4));
  endtask

  int grants[$];

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 19'h12345; req0_b = 19'h54321; req0_op = 5'b01001;
    req1_valid = 1'b1; req1_a = 19'h00001; req1_b = 19'h00002; req1_op = 5'b01010;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset with both requesters valid
    repeat (2) @(posedge clk);
    #2;
    check("rst_lu_a",      32'(lu_a),       32'h0);
    check("rst_lu_b",      32'(lu_b),       32'h0);
    check("rst_lu_opcode", 32'(lu_opcode),  32'h0);
    check("rst_busy",      32'(busy),       32'h0);
    check("rst_ready0",    32'(req0_ready), 32'h0);
    check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'h0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(posedge clk); #1;

    // AND with fixed expected values, rsp two cycles after accept
    issue(0, 19'h7FFFF, 19'h00F0F, 5'b01000);
    @(posedge clk); #2;
    check("and_rsp0_valid", 32'(rsp0_valid), 32'h1);
    check("and_rsp0_data",  32'(rsp0_data),  32'h00F0F);
    check("and_rsp0_flags", 32'(rsp0_flags), 32'b01000);
    check("and_rsp0_err",   32'(rsp0_err),   32'h0);
    @(posedge clk); #1;

    // Invalid opcode on req1
    issue(1, 19'h0, 19'h0, 5'b11111);
    @(posedge clk); #2;
    check("bad_rsp1_valid", 32'(rsp1_valid), 32'h1);
    check("bad_rsp1_err",   32'(rsp1_err),   32'h1);
    check("bad_rsp1_data",  32'(rsp1_data),  32'h0);
    check("bad_rsp1_flags", 32'(rsp1_flags), 32'b10011);
    @(posedge clk); #1;

    // Both requesters valid continuously
    hs0 = 1'b0; hs1 = 1'b0;
    req0_a = 19'h0AAAA; req0_b = 19'h05555; req0_op = 5'b01001; req0_valid = 1'b1;
    req1_a = 19'h33333; req1_b = 19'h33333; req1_op = 5'b01010; req1_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (hs0) begin grants.push_back(0); hs0 = 1'b0; end
      if (hs1) begin grants.push_back(1); hs1 = 1'b0; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("alt_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size(); i++) begin
`ifdef LUARB_FIXED_PRIO_EN
      check("fixed_grant", 32'(grants[i]), 32'd0);
`else
      check("rr_grant", 32'(grants[i]), 32'(i % 2));
`endif
    end
    repeat (4) @(posedge clk); #1;

    // Response back-pressure on req0 while req1 waits
    rsp0_ready = 1'b0;
    issue(0, 19'h1F0F0, 19'h0FFFF, 5'b01011);
    req1_a = 19'h00123; req1_b = 19'h00456; req1_op = 5'b01100; req1_valid = 1'b1; hs1 = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      #2;
      check("hold_rsp0_valid", 32'(rsp0_valid), 32'h1);
      check("hold_busy",       32'(busy),       32'h1);
      check("hold_readies",    32'({req0_ready, req1_ready}), 32'h0);
      @(posedge clk);
    end
    #1 rsp0_ready = 1'b1;
    @(posedge clk); #2;
    check("release_busy", 32'(busy), 32'h0);
    wait_hs(1);
    repeat (3) @(posedge clk); #1;

    // Reset during EXEC, then tie resolves toward req0
    issue(1, 19'h00F00, 19'h000F0, 5'b01001);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("post_rst_rsp1_valid", 32'(rsp1_valid), 32'h0);
    #1;
    hs0 = 1'b0; hs1 = 1'b0;
    req0_a = 19'h00007; req0_b = 19'h00003; req0_op = 5'b01000; req0_valid = 1'b1;
    req1_a = 19'h00001; req1_b = 19'h00001; req1_op = 5'b01000; req1_valid = 1'b1;
    wait_hs(0);
    check("post_rst_first_grant_req1", 32'(hs1), 32'h0);
    req1_valid = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Randomised traffic
    hs0 = 1'b0; hs1 = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (hs0) begin hs0 = 1'b0; req0_valid = 1'b0; end
      if (hs1) begin hs1 = 1'b0; req1_valid = 1'b0; end
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        rand_payload(req0_a, req0_b, req0_op);
        req0_valid = 1'b1;
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        rand_payload(req1_a, req1_b, req1_op);
        req1_valid = 1'b1;
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
